// File: rtl/recovery_ctrl.sv
// rtl/recovery_ctrl.sv - oldest-mispredict / exception recovery sequencer around the ROB
// Optional macro RECOVERY_CTRL_PERF_EN builds the recovery and stall performance counters.
module recovery_ctrl #(
    parameter int          ROB_SIZE       = 32,
    parameter int          NUM_BR         = 2,
    parameter int          RESTORE_CYCLES = 2,
    parameter logic [31:0] EXC_VECTOR     = 32'h0000_0100,
    localparam int         IDX            = $clog2(ROB_SIZE)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_BR-1:0]     br_valid,
    input  logic [NUM_BR-1:0]     br_mispredict,
    input  logic [IDX*NUM_BR-1:0] br_rob_idx,
    input  logic [32*NUM_BR-1:0]  br_target,
    input  logic [IDX-1:0]        rob_head,
    input  logic                  commit_exc_valid,
    input  logic [31:0]           commit_exc_pc,
    output logic                  commit_stop_valid,
    output logic [IDX-1:0]        commit_stop_idx,
    output logic                  flush_en,
    output logic [IDX-1:0]        flush_ptr,
    output logic                  restore_en,
    output logic [IDX-1:0]        restore_rob_idx,
    output logic                  redirect_valid,
    output logic [31:0]           redirect_pc,
    input  logic                  redirect_ready,
    output logic [31:0]           exc_pc,
    output logic                  dispatch_stall,
    output logic                  busy,
    output logic [31:0]           perf_recoveries,
    output logic [31:0]           perf_stall_cycles
);
    localparam int CW = (RESTORE_CYCLES > 1) ? $clog2(RESTORE_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_FLUSH,
        S_RESTORE,
        S_REDIRECT
    } state_t;

    state_t         state, state_n;
    logic [IDX-1:0] pend_idx, pend_idx_n;
    logic [IDX-1:0] pend_ptr, pend_ptr_n;
    logic [31:0]    pend_pc, pend_pc_n;
    logic [31:0]    exc_pc_q, exc_pc_n;
    logic [CW-1:0]  cnt, cnt_n;

    logic           mp_any;
    logic [IDX-1:0] mp_idx;
    logic [IDX-1:0] mp_age;
    logic [31:0]    mp_pc;
    logic [IDX-1:0] pend_age;
    logic           drained;
    logic           take_exc;

    // Oldest mispredict this cycle; strict compare keeps the lower port on equal age.
    always_comb begin
        mp_any = 1'b0;
        mp_idx = '0;
        mp_age = '0;
        mp_pc  = '0;
        for (int p = 0; p < NUM_BR; p++) begin
            if (br_valid[p] && br_mispredict[p] &&
                (!mp_any || ((br_rob_idx[p*IDX +: IDX] - rob_head) < mp_age))) begin
                mp_any = 1'b1;
                mp_idx = br_rob_idx[p*IDX +: IDX];
                mp_age = br_rob_idx[p*IDX +: IDX] - rob_head;
                mp_pc  = br_target[p*32 +: 32];
            end
        end
    end

    assign pend_age = pend_idx - rob_head;
    assign drained  = (rob_head == (pend_idx + IDX'(1)));
    assign take_exc = commit_exc_valid && ((state == S_IDLE) || (state == S_DRAIN));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            pend_idx <= '0;
            pend_ptr <= '0;
            pend_pc  <= '0;
            exc_pc_q <= '0;
            cnt      <= '0;
        end else begin
            state    <= state_n;
            pend_idx <= pend_idx_n;
            pend_ptr <= pend_ptr_n;
            pend_pc  <= pend_pc_n;
            exc_pc_q <= exc_pc_n;
            cnt      <= cnt_n;
        end
    end

    always_comb begin
        state_n    = state;
        pend_idx_n = pend_idx;
        pend_ptr_n = pend_ptr;
        pend_pc_n  = pend_pc;
        exc_pc_n   = exc_pc_q;
        cnt_n      = cnt;
        if (take_exc) begin
            state_n    = S_FLUSH;
            pend_ptr_n = rob_head;
            pend_pc_n  = EXC_VECTOR;
            exc_pc_n   = commit_exc_pc;
        end else begin
            case (state)
                S_IDLE: begin
                    if (mp_any) begin
                        pend_idx_n = mp_idx;
                        pend_pc_n  = mp_pc;
                        state_n    = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // Once the branch has retired, any new "older" age is only wrap-around noise.
                    if (drained) begin
                        pend_ptr_n = rob_head;
                        state_n    = S_FLUSH;
                    end else if (mp_any && (mp_age < pend_age)) begin
                        pend_idx_n = mp_idx;
                        pend_pc_n  = mp_pc;
                    end
                end
                S_FLUSH: begin
                    cnt_n   = CW'(RESTORE_CYCLES - 1);
                    state_n = S_RESTORE;
                end
                S_RESTORE: begin
                    if (cnt == '0) begin
                        state_n = S_REDIRECT;
                    end else begin
                        cnt_n = cnt - CW'(1);
                    end
                end
                S_REDIRECT: begin
                    if (redirect_ready) begin
                        state_n = S_IDLE;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    assign commit_stop_valid = (state == S_DRAIN);
    assign commit_stop_idx   = (state == S_DRAIN) ? pend_idx : '0;
    assign flush_en          = (state == S_FLUSH);
    assign flush_ptr         = (state == S_FLUSH) ? pend_ptr : '0;
    assign restore_en        = (state == S_RESTORE);
    assign restore_rob_idx   = (state == S_RESTORE) ? pend_ptr : '0;
    assign redirect_valid    = (state == S_REDIRECT);
    assign redirect_pc       = (state == S_REDIRECT) ? pend_pc : '0;
    assign exc_pc            = exc_pc_q;
    assign dispatch_stall    = (state != S_IDLE);
    assign busy              = (state != S_IDLE);

`ifdef RECOVERY_CTRL_PERF_EN
    logic [31:0] rec_cnt;
    logic [31:0] stall_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rec_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            if ((state == S_REDIRECT) && redirect_ready && (rec_cnt != 32'hFFFF_FFFF)) begin
                rec_cnt <= rec_cnt + 32'd1;
            end
            if ((state != S_IDLE) && (stall_cnt != 32'hFFFF_FFFF)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

    assign perf_recoveries   = rec_cnt;
    assign perf_stall_cycles = stall_cnt;
`else
    assign perf_recoveries   = '0;
    assign perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_recovery_ctrl.sv
// tb/tb_recovery_ctrl.sv - table-driven self-checking bench for recovery_ctrl
module tb_recovery_ctrl;
    localparam int ID = 0;
    localparam int DR = 1;
    localparam int FL = 2;
    localparam int RS = 3;
    localparam int RD = 4;
`ifdef RECOVERY_CTRL_PERF_EN
    localparam int PERF = 1;
`else
    localparam int PERF = 0;
`endif

    logic        clk;
    logic        reset;
    logic [1:0]  br_valid;
    logic [1:0]  br_mispredict;
    logic [9:0]  br_rob_idx;
    logic [63:0] br_target;
    logic [4:0]  rob_head;
    logic        commit_exc_valid;
    logic [31:0] commit_exc_pc;
    logic        commit_stop_valid;
    logic [4:0]  commit_stop_idx;
    logic        flush_en;
    logic [4:0]  flush_ptr;
    logic        restore_en;
    logic [4:0]  restore_rob_idx;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;
    logic [31:0] exc_pc;
    logic        dispatch_stall;
    logic        busy;
    logic [31:0] perf_recoveries;
    logic [31:0] perf_stall_cycles;

    recovery_ctrl dut (
        .clk               (clk),
        .reset             (reset),
        .br_valid          (br_valid),
        .br_mispredict     (br_mispredict),
        .br_rob_idx        (br_rob_idx),
        .br_target         (br_target),
        .rob_head          (rob_head),
        .commit_exc_valid  (commit_exc_valid),
        .commit_exc_pc     (commit_exc_pc),
        .commit_stop_valid (commit_stop_valid),
        .commit_stop_idx   (commit_stop_idx),
        .flush_en          (flush_en),
        .flush_ptr         (flush_ptr),
        .restore_en        (restore_en),
        .restore_rob_idx   (restore_rob_idx),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .redirect_ready    (redirect_ready),
        .exc_pc            (exc_pc),
        .dispatch_stall    (dispatch_stall),
        .busy              (busy),
        .perf_recoveries   (perf_recoveries),
        .perf_stall_cycles (perf_stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  bv;
        logic [1:0]  bm;
        logic [4:0]  i0;
        logic [4:0]  i1;
        logic [31:0] t0;
        logic [31:0] t1;
        logic [4:0]  head;
        logic        ev;
        logic [31:0] epc;
        logic        rdy;
        logic        x_stop;
        logic [4:0]  x_sidx;
        logic        x_fl;
        logic [4:0]  x_fptr;
        logic        x_rest;
        logic [4:0]  x_ridx;
        logic        x_rv;
        logic [31:0] x_rpc;
        logic        x_busy;
        logic [31:0] x_exc;
    } vec_t;

    int n_chk  = 0;
    int n_fail = 0;

    // st names the state expected after the edge; xv is that state's index or PC value.
    function automatic vec_t mk(input int head, input int ev, input logic [31:0] epc,
                                input int bv, input int bm, input int i0, input logic [31:0] t0,
                                input int i1, input logic [31:0] t1, input int rdy,
                                input int st, input logic [31:0] xv, input logic [31:0] xexc);
        vec_t v;
        v.head   = 5'(head);
        v.ev     = (ev != 0);
        v.epc    = epc;
        v.bv     = 2'(bv);
        v.bm     = 2'(bm);
        v.i0     = 5'(i0);
        v.t0     = t0;
        v.i1     = 5'(i1);
        v.t1     = t1;
        v.rdy    = (rdy != 0);
        v.x_stop = (st == DR);
        v.x_sidx = (st == DR) ? 5'(xv) : 5'd0;
        v.x_fl   = (st == FL);
        v.x_fptr = (st == FL) ? 5'(xv) : 5'd0;
        v.x_rest = (st == RS);
        v.x_ridx = (st == RS) ? 5'(xv) : 5'd0;
        v.x_rv   = (st == RD);
        v.x_rpc  = (st == RD) ? xv : 32'd0;
        v.x_busy = (st != ID);
        v.x_exc  = xexc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        br_valid         = v.bv;
        br_mispredict    = v.bm;
        br_rob_idx       = {v.i1, v.i0};
        br_target        = {v.t1, v.t0};
        rob_head         = v.head;
        commit_exc_valid = v.ev;
        commit_exc_pc    = v.epc;
        redirect_ready   = v.rdy;
        @(posedge clk);
        #1;
        chk({tag, " commit_stop_valid"}, 32'(commit_stop_valid), 32'(v.x_stop));
        chk({tag, " commit_stop_idx"},   32'(commit_stop_idx),   32'(v.x_sidx));
        chk({tag, " flush_en"},          32'(flush_en),          32'(v.x_fl));
        chk({tag, " flush_ptr"},         32'(flush_ptr),         32'(v.x_fptr));
        chk({tag, " restore_en"},        32'(restore_en),        32'(v.x_rest));
        chk({tag, " restore_rob_idx"},   32'(restore_rob_idx),   32'(v.x_ridx));
        chk({tag, " redirect_valid"},    32'(redirect_valid),    32'(v.x_rv));
        chk({tag, " redirect_pc"},       redirect_pc,            v.x_rpc);
        chk({tag, " dispatch_stall"},    32'(dispatch_stall),    32'(v.x_busy));
        chk({tag, " busy"},              32'(busy),              32'(v.x_busy));
        chk({tag, " exc_pc"},            exc_pc,                 v.x_exc);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " commit_stop_valid"}, 32'(commit_stop_valid), 32'd0);
        chk({tag, " commit_stop_idx"},   32'(commit_stop_idx),   32'd0);
        chk({tag, " flush_en"},          32'(flush_en),          32'd0);
        chk({tag, " flush_ptr"},         32'(flush_ptr),         32'd0);
        chk({tag, " restore_en"},        32'(restore_en),        32'd0);
        chk({tag, " restore_rob_idx"},   32'(restore_rob_idx),   32'd0);
        chk({tag, " redirect_valid"},    32'(redirect_valid),    32'd0);
        chk({tag, " redirect_pc"},       redirect_pc,            32'd0);
        chk({tag, " exc_pc"},            exc_pc,                 32'd0);
        chk({tag, " dispatch_stall"},    32'(dispatch_stall),    32'd0);
        chk({tag, " busy"},              32'(busy),              32'd0);
        chk({tag, " perf_recoveries"},   perf_recoveries,        32'd0);
        chk({tag, " perf_stall_cycles"}, perf_stall_cycles,      32'd0);
    endtask

    vec_t tbl[$];
    int   exp_stall;

    initial begin
        // exception in IDLE at head 5
        tbl.push_back(mk(5, 1, 'h400, 0, 0, 0, 0, 0, 0, 1, FL, 5, 'h400));
        tbl.push_back(mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 1, RS, 5, 'h400));
        tbl.push_back(mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 1, RS, 5, 'h400));
        tbl.push_back(mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 1, RD, 'h100, 'h400));
        tbl.push_back(mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 1, ID, 0, 'h400));
        // two-port oldest select, pend_idx 31 drains at head 0
        tbl.push_back(mk(30, 0, 0, 3, 3, 2, 'h200, 31, 'h300, 0, DR, 31, 'h400));
        tbl.push_back(mk(31, 0, 0, 0, 0, 0, 0, 0, 0, 0, DR, 31, 'h400));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, FL, 0, 'h400));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RS, 0, 'h400));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RS, 0, 'h400));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RD, 'h300, 'h400));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, ID, 0, 'h400));
        // replacement by an older mispredict, younger one ignored
        tbl.push_back(mk(8, 0, 0, 1, 1, 10, 'hA00, 0, 0, 0, DR, 10, 'h400));
        tbl.push_back(mk(8, 0, 0, 2, 2, 0, 0, 9, 'h900, 0, DR, 9, 'h400));
        tbl.push_back(mk(9, 0, 0, 1, 1, 20, 'hBAD, 0, 0, 0, DR, 9, 'h400));
        tbl.push_back(mk(10, 0, 0, 0, 0, 0, 0, 0, 0, 0, FL, 10, 'h400));
        tbl.push_back(mk(10, 0, 0, 0, 0, 0, 0, 0, 0, 0, RS, 10, 'h400));
        tbl.push_back(mk(10, 0, 0, 0, 0, 0, 0, 0, 0, 0, RS, 10, 'h400));
        tbl.push_back(mk(10, 0, 0, 0, 0, 0, 0, 0, 0, 0, RD, 'h900, 'h400));
        tbl.push_back(mk(10, 0, 0, 0, 0, 0, 0, 0, 0, 1, ID, 0, 'h400));
        // exception overrides DRAIN
        tbl.push_back(mk(11, 0, 0, 1, 1, 12, 'hC00, 0, 0, 0, DR, 12, 'h400));
        tbl.push_back(mk(11, 1, 'h1234, 0, 0, 0, 0, 0, 0, 0, FL, 11, 'h1234));
        tbl.push_back(mk(11, 0, 0, 0, 0, 0, 0, 0, 0, 0, RS, 11, 'h1234));
        tbl.push_back(mk(11, 0, 0, 0, 0, 0, 0, 0, 0, 0, RS, 11, 'h1234));
        tbl.push_back(mk(11, 0, 0, 0, 0, 0, 0, 0, 0, 0, RD, 'h100, 'h1234));
        tbl.push_back(mk(11, 0, 0, 0, 0, 0, 0, 0, 0, 1, ID, 0, 'h1234));
        // backpressure with wrong-path branch/exception traffic
        tbl.push_back(mk(3, 1, 'h500, 0, 0, 0, 0, 0, 0, 0, FL, 3, 'h500));
        tbl.push_back(mk(3, 0, 0, 3, 3, 4, 'h444, 5, 'h555, 0, RS, 3, 'h500));
        tbl.push_back(mk(3, 1, 'h999, 0, 0, 0, 0, 0, 0, 0, RS, 3, 'h500));
        tbl.push_back(mk(3, 0, 0, 3, 3, 1, 'h111, 2, 'h222, 0, RD, 'h100, 'h500));
        tbl.push_back(mk(3, 0, 0, 3, 3, 1, 'h111, 2, 'h222, 0, RD, 'h100, 'h500));
        tbl.push_back(mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, RD, 'h100, 'h500));
        tbl.push_back(mk(3, 1, 'h999, 3, 3, 1, 'h111, 2, 'h222, 0, RD, 'h100, 'h500));
        tbl.push_back(mk(3, 0, 0, 3, 3, 1, 'h111, 2, 'h222, 1, ID, 0, 'h500));
        tbl.push_back(mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, ID, 0, 'h500));
        // equal age: lower port wins
        tbl.push_back(mk(0, 0, 0, 3, 3, 6, 'h600, 6, 'h6FF, 0, DR, 6, 'h500));
        tbl.push_back(mk(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, FL, 7, 'h500));
        tbl.push_back(mk(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, RS, 7, 'h500));
        tbl.push_back(mk(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, RS, 7, 'h500));
        tbl.push_back(mk(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, RD, 'h600, 'h500));
        tbl.push_back(mk(7, 0, 0, 0, 0, 0, 0, 0, 0, 1, ID, 0, 'h500));

        reset            = 1'b1;
        br_valid         = '0;
        br_mispredict    = '0;
        br_rob_idx       = '0;
        br_target        = '0;
        rob_head         = '0;
        commit_exc_valid = 1'b0;
        commit_exc_pc    = '0;
        redirect_ready   = 1'b0;
        #1;
        chk_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        exp_stall = 0;
        for (int r = 0; r < tbl.size(); r++) begin
            run_vec(tbl[r], $sformatf("row%0d", r));
            exp_stall += tbl[r].x_busy ? 1 : 0;
        end
        chk("perf_recoveries", perf_recoveries, (PERF != 0) ? 32'd6 : 32'd0);
        chk("perf_stall_cycles", perf_stall_cycles, (PERF != 0) ? 32'(exp_stall) : 32'd0);

        // exception beats a same-cycle mispredict, then reset lands in RESTORE
        run_vec(mk(7, 1, 'h700, 1, 1, 7, 'h777, 0, 0, 0, FL, 7, 'h700), "exc_vs_br");
        run_vec(mk(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, RS, 7, 'h700), "pre_reset");
        reset = 1'b1;
        #1;
        chk_zero("async_reset");
        @(posedge clk);
        #1;
        chk_zero("held_reset");
        reset = 1'b0;

        run_vec(mk(9, 1, 'h900, 0, 0, 0, 0, 0, 0, 1, FL, 9, 'h900), "post0");
        run_vec(mk(9, 0, 0, 0, 0, 0, 0, 0, 0, 1, RS, 9, 'h900), "post1");
        run_vec(mk(9, 0, 0, 0, 0, 0, 0, 0, 0, 1, RS, 9, 'h900), "post2");
        run_vec(mk(9, 0, 0, 0, 0, 0, 0, 0, 0, 1, RD, 'h100, 'h900), "post3");
        run_vec(mk(9, 0, 0, 0, 0, 0, 0, 0, 0, 1, ID, 0, 'h900), "post4");
        chk("post perf_recoveries", perf_recoveries, (PERF != 0) ? 32'd1 : 32'd0);
        chk("post perf_stall_cycles", perf_stall_cycles, (PERF != 0) ? 32'd4 : 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
